binary_bbox_detector: RTL and testbench



---
 rtl/gesture_pkg.sv | 17 +
 rtl/binary_bbox_detector_edge.sv | 23 ++
 rtl/binary_bbox_detector.sv | 154 +++++++++++++++
 tb/tb_binary_bbox_detector.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gesture_pkg.sv
// Shared types and defaults for the binary bounding-box detector.
// State encoding, default image geometry and the min-tracker start value.
package gesture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    LATCH  = 2'd2
  } state_t;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  // Min trackers start here so the first foreground pixel always wins.
  localparam logic [31:0] COORD_SENTINEL = 32'hFFFF_FFFF;

endpackage

// File: rtl/binary_bbox_detector_edge.sv
// One-register edge detector: rise/fall are combinational, valid in the cycle the input changes.
// No backpressure; RESET_VAL picks what the input is assumed to have been before reset released.
module signal_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_d <= RESET_VAL;
    else        sig_d <= sig;
  end

  assign rise = sig & ~sig_d;
  assign fall = ~sig & sig_d;

endmodule

// File: rtl/binary_bbox_detector.sv
// Per-frame foreground bounding box and pixel count; results register 2 edges after vsync falls.
// No backpressure: every pixel strobe is consumed; frame_done pulses while LATCH is held.
module binary_bbox_detector
  import gesture_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int XW         = 10,
  parameter int YW         = 10,
  parameter int CNTW       = 19,
  parameter int MIN_PIXELS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            per_frame_vsync,
  input  logic            per_frame_hsync,
  input  logic            per_frame_clken,
  input  logic [15:0]     per_img_Y,
  output logic [XW-1:0]   box_x_min,
  output logic [XW-1:0]   box_x_max,
  output logic [YW-1:0]   box_y_min,
  output logic [YW-1:0]   box_y_max,
  output logic [CNTW-1:0] pix_count,
  output logic            box_valid,
  output logic            frame_done
);

  localparam logic [XW-1:0]   COL_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]   ROW_LAST = YW'(IMG_H - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  state_t          state, state_nxt;
  logic            vs_rise, vs_fall, hs_rise, hs_fall;
  logic [XW-1:0]   col, col_cur;
  logic            line_full, full_cur;
  logic [YW-1:0]   row;
  logic [XW-1:0]   x_min, x_max;
  logic [YW-1:0]   y_min, y_max;
  logic [CNTW-1:0] cnt;
  logic            accept, fg, frame_start;
  logic            unused_y_bits;

  assign unused_y_bits = ^per_img_Y[15:1];

  // vsync edge register resets high so a frame already in flight at reset release is skipped.
  signal_edge_detect #(.RESET_VAL(1'b1)) u_vs_edge (
    .clk(clk), .rst_n(rst_n), .sig(per_frame_vsync), .rise(vs_rise), .fall(vs_fall)
  );

  signal_edge_detect #(.RESET_VAL(1'b0)) u_hs_edge (
    .clk(clk), .rst_n(rst_n), .sig(per_frame_hsync), .rise(hs_rise), .fall(hs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vs_rise) state_nxt = ACTIVE;
      ACTIVE:  if (vs_fall) state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_done = (state == LATCH);
  end

  assign frame_start = (state == IDLE) && vs_rise;
  assign accept      = (state == ACTIVE) && per_frame_hsync && per_frame_clken;
  assign fg          = accept && per_img_Y[0];

  // A pixel arriving on the hsync-rise cycle itself is column 0.
  assign col_cur  = hs_rise ? '0 : col;
  assign full_cur = hs_rise ? 1'b0 : line_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      line_full <= 1'b0;
    end else if (accept) begin
      col       <= (col_cur == COL_LAST) ? col_cur : col_cur + 1'b1;
      line_full <= full_cur | (col_cur == COL_LAST);
    end else if (hs_rise) begin
      col       <= '0;
      line_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
    end else if (frame_start) begin
      row <= '0;
    end else if ((state == ACTIVE) && hs_fall && (row != ROW_LAST)) begin
      row <= row + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_min <= '0;
      x_max <= '0;
      y_min <= '0;
      y_max <= '0;
      cnt   <= '0;
    end else if (frame_start) begin
      x_min <= COORD_SENTINEL[XW-1:0];
      x_max <= '0;
      y_min <= COORD_SENTINEL[YW-1:0];
      y_max <= '0;
      cnt   <= '0;
    end else if (fg) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      // Pixels past the last column still count but do not move the box.
      if (!full_cur) begin
        if (col_cur < x_min) x_min <= col_cur;
        if (col_cur > x_max) x_max <= col_cur;
        if (row < y_min)     y_min <= row;
        if (row > y_max)     y_max <= row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_x_min <= '0;
      box_x_max <= '0;
      box_y_min <= '0;
      box_y_max <= '0;
      pix_count <= '0;
      box_valid <= 1'b0;
    end else if (state == LATCH) begin
      if (cnt == '0) begin
        box_x_min <= '0;
        box_x_max <= '0;
        box_y_min <= '0;
        box_y_max <= '0;
      end else begin
        box_x_min <= x_min;
        box_x_max <= x_max;
        box_y_min <= y_min;
        box_y_max <= y_max;
      end
      pix_count <= cnt;
      box_valid <= (cnt >= CNTW'(MIN_PIXELS));
    end
  end

endmodule

// File: tb/tb_binary_bbox_detector.sv
// Randomized and directed frames against a line/pixel-list reference model of the box rules.
module tb_binary_bbox_detector;

  localparam int W = 8;
  localparam int H = 6;
  localparam int MINP = 2;
  localparam int CNTW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0, hsync = 1'b0, clken = 1'b0;
  logic [15:0] img_y = '0;
  logic [2:0] x_min, x_max, y_min, y_max;
  logic [CNTW-1:0] pcount;
  logic       valid, done;

  binary_bbox_detector #(
    .IMG_W(W), .IMG_H(H), .XW(3), .YW(3), .CNTW(CNTW), .MIN_PIXELS(MINP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_hsync(hsync), .per_frame_clken(clken),
    .per_img_Y(img_y),
    .box_x_min(x_min), .box_x_max(x_max), .box_y_min(y_min), .box_y_max(y_max),
    .pix_count(pcount), .box_valid(valid), .frame_done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int exp_done = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Frame description: per line, the foreground flag of each pixel strobe in order.
  int n_lines;
  int line_len [0:7];
  bit line_pix [0:7][0:15];

  int e_xmin, e_xmax, e_ymin, e_ymax, e_cnt, e_valid;
  int p_xmin = 0, p_xmax = 0, p_ymin = 0, p_ymax = 0, p_cnt = 0, p_valid = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hsync = 1'b0;
    for (int i = 0; i < n; i++) begin
      clken = 1'($urandom_range(0, 1));
      img_y = 16'hFFFF;
      tick();
    end
    clken = 1'b0;
  endtask

  task automatic clear_frame(input int nl, input int len);
    n_lines = nl;
    for (int i = 0; i < 8; i++) begin
      line_len[i] = len;
      for (int k = 0; k < 16; k++) line_pix[i][k] = 1'b0;
    end
  endtask

  // Line i is row min(i, H-1); strobe k of a line is column k, and only the first W strobes shape the box.
  task automatic model();
    int c;
    int r;
    c = 0;
    e_xmin = W - 1; e_xmax = 0; e_ymin = 7; e_ymax = 0;
    for (int i = 0; i < n_lines; i++) begin
      r = (i < H) ? i : H - 1;
      for (int k = 0; k < line_len[i]; k++) begin
        if (line_pix[i][k]) begin
          c++;
          if (k < W) begin
            if (k < e_xmin) e_xmin = k;
            if (k > e_xmax) e_xmax = k;
            if (r < e_ymin) e_ymin = r;
            if (r > e_ymax) e_ymax = r;
          end
        end
      end
    end
    e_cnt = (c > 255) ? 255 : c;
    e_valid = (e_cnt >= MINP) ? 1 : 0;
    if (e_cnt == 0) begin
      e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
    end
  endtask

  task automatic send_lines();
    int k;
    for (int i = 0; i < n_lines; i++) begin
      hsync = 1'b1;
      k = 0;
      do begin
        if (k < line_len[i] && $urandom_range(0, 3) != 0) begin
          clken = 1'b1;
          img_y = {16{line_pix[i][k]}};
          k++;
        end else begin
          clken = 1'b0;
          img_y = 16'($urandom);
        end
        tick();
      end while (k < line_len[i]);
      idle(1 + $urandom_range(0, 1));
    end
  endtask

  task automatic check_outs(input string tag, input int xa, input int xb, input int ya,
                            input int yb, input int cn, input int vl);
    chk({tag, ".x_min"}, x_min, xa);
    chk({tag, ".x_max"}, x_max, xb);
    chk({tag, ".y_min"}, y_min, ya);
    chk({tag, ".y_max"}, y_max, yb);
    chk({tag, ".count"}, pcount, cn);
    chk({tag, ".valid"}, valid, vl);
  endtask

  task automatic run_frame(input string tag);
    model();
    vsync = 1'b1;
    idle(2);
    send_lines();
    idle(1);
    check_outs({tag, ".hold"}, p_xmin, p_xmax, p_ymin, p_ymax, p_cnt, p_valid);
    vsync = 1'b0;
    tick();
    chk({tag, ".done_hi"}, done, 1);
    chk({tag, ".old_xmin"}, x_min, p_xmin);
    chk({tag, ".old_count"}, pcount, p_cnt);
    tick();
    chk({tag, ".done_lo"}, done, 0);
    check_outs(tag, e_xmin, e_xmax, e_ymin, e_ymax, e_cnt, e_valid);
    exp_done++;
    chk({tag, ".done_cnt"}, done_cnt, exp_done);
    p_xmin = e_xmin; p_xmax = e_xmax; p_ymin = e_ymin;
    p_ymax = e_ymax; p_cnt = e_cnt; p_valid = e_valid;
  endtask

  initial begin
    repeat (3) tick();
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.done", done, 0);
    rst_n = 1'b1;
    idle(3);

    // 3x2 block at cols 2-4, rows 1-2
    clear_frame(6, 8);
    for (int r = 1; r <= 2; r++)
      for (int c = 2; c <= 4; c++) line_pix[r][c] = 1'b1;
    run_frame("block");

    clear_frame(6, 8);
    run_frame("empty");

    clear_frame(6, 8);
    line_pix[5][7] = 1'b1;
    run_frame("corner");

    // Overlong line: strobes 6..9 are foreground, only columns 6 and 7 shape the box
    clear_frame(2, 8);
    line_len[0] = 10;
    for (int k = 6; k < 10; k++) line_pix[0][k] = 1'b1;
    run_frame("overrun");

    // Reset mid-frame, released with vsync still high: the frame must vanish
    clear_frame(3, 8);
    line_pix[1][1] = 1'b1;
    vsync = 1'b1;
    idle(2);
    send_lines();
    rst_n = 1'b0;
    tick();
    tick();
    check_outs("midrst", 0, 0, 0, 0, 0, 0);
    chk("midrst.done", done, 0);
    rst_n = 1'b1;
    send_lines();
    vsync = 1'b0;
    idle(4);
    chk("midrst.no_done", done_cnt, exp_done);
    p_xmin = 0; p_xmax = 0; p_ymin = 0; p_ymax = 0; p_cnt = 0; p_valid = 0;

    clear_frame(6, 8);
    line_pix[0][0] = 1'b1;
    line_pix[3][5] = 1'b1;
    run_frame("after_rst");

    // Back-to-back frames with different boxes
    clear_frame(4, 8);
    line_pix[2][6] = 1'b1;
    line_pix[3][6] = 1'b1;
    run_frame("b2b_a");
    clear_frame(6, 8);
    line_pix[1][3] = 1'b1;
    line_pix[4][1] = 1'b1;
    line_pix[4][2] = 1'b1;
    run_frame("b2b_b");

    for (int f = 0; f < 25; f++) begin
      int dens;
      dens = $urandom_range(0, 100);
      clear_frame($urandom_range(1, 8), 0);
      for (int i = 0; i < 8; i++) begin
        line_len[i] = $urandom_range(0, 11);
        for (int k = 0; k < 16; k++) line_pix[i][k] = ($urandom_range(0, 99) < dens);
      end
      run_frame($sformatf("rand%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
